// File: rtl/corr_argmax.sv
// Atom selection for OMP: streams every dictionary column, correlates it with the residual
// and reports the column with the largest |<r, a_j>|. Optional macro CORR_MASK_EN adds col_mask.
module corr_argmax #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned VEC_LEN        = 32,
    parameter int unsigned NUM_COLS       = 256,
    parameter int unsigned ROM_ADDR_WIDTH = 13,
    parameter int unsigned IDX_WIDTH      = 8,
    parameter int unsigned ACC_WIDTH      = 2 * DATA_WIDTH + $clog2(VEC_LEN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           res_rd_en,
    input  logic [DATA_WIDTH*VEC_LEN-1:0]  res_vec,
    output logic                           rom_rd_en,
    output logic [ROM_ADDR_WIDTH-1:0]      rom_addr,
    input  logic [DATA_WIDTH-1:0]          rom_data,
`ifdef CORR_MASK_EN
    input  logic [NUM_COLS-1:0]            col_mask,
`endif
    output logic                           busy,
    output logic                           done,
    output logic [IDX_WIDTH-1:0]           best_idx,
    output logic [ACC_WIDTH-1:0]           best_corr
);

    localparam int unsigned ROW_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned MAG_W  = ACC_WIDTH + 1;
    localparam logic [ROW_W-1:0]     ROW_LAST = ROW_W'(VEC_LEN - 1);
    localparam logic [IDX_WIDTH-1:0] COL_LAST = IDX_WIDTH'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                    state;
    state_t                    state_nx;
    logic                      res_rd_en_nx;
    logic                      rom_rd_en_nx;
    logic                      busy_nx;
    logic                      done_nx;
    logic [ROM_ADDR_WIDTH-1:0] addr_nx;
    logic [ROW_W-1:0]          row;
    logic [ROW_W-1:0]          row_nx;
    logic [IDX_WIDTH-1:0]      col;
    logic [IDX_WIDTH-1:0]      col_nx;

    // FSM state and all control outputs are registered from their next values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            res_rd_en <= 1'b0;
            rom_rd_en <= 1'b0;
            rom_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            row       <= '0;
            col       <= '0;
        end else begin
            state     <= state_nx;
            res_rd_en <= res_rd_en_nx;
            rom_rd_en <= rom_rd_en_nx;
            rom_addr  <= addr_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            row       <= row_nx;
            col       <= col_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        res_rd_en_nx = 1'b0;
        rom_rd_en_nx = 1'b0;
        busy_nx      = 1'b1;
        done_nx      = 1'b0;
        addr_nx      = '0;
        row_nx       = row;
        col_nx       = col;
        case (state)
            IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx     = LOAD;
                    res_rd_en_nx = 1'b1;
                    busy_nx      = 1'b1;
                end
            end
            LOAD: begin
                state_nx     = RUN;
                rom_rd_en_nx = 1'b1;
                row_nx       = '0;
                col_nx       = '0;
            end
            RUN: begin
                if (row == ROW_LAST && col == COL_LAST) begin
                    state_nx = DRAIN;
                    row_nx   = '0;
                    col_nx   = '0;
                end else begin
                    rom_rd_en_nx = 1'b1;
                    addr_nx      = rom_addr + ROM_ADDR_WIDTH'(1);
                    if (row == ROW_LAST) begin
                        row_nx = '0;
                        col_nx = col + IDX_WIDTH'(1);
                    end else begin
                        row_nx = row + ROW_W'(1);
                    end
                end
            end
            DRAIN: begin
                state_nx = DONE;
                done_nx  = 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // MAC stage: one cycle behind address issue, tagged with the row/col that was read
    logic                        mac_vld;
    logic [ROW_W-1:0]            mac_row;
    logic [IDX_WIDTH-1:0]        mac_col;
    logic signed [ACC_WIDTH-1:0] acc;

    logic signed [DATA_WIDTH-1:0] res_elem [VEC_LEN];
    logic signed [DATA_WIDTH-1:0] elem_c;
    logic signed [DATA_WIDTH-1:0] rom_s;
    logic signed [PROD_W-1:0]     prod_c;
    logic signed [ACC_WIDTH-1:0]  prod_ext_c;
    logic signed [ACC_WIDTH-1:0]  final_c;
    logic signed [MAG_W-1:0]      ext_c;
    logic [MAG_W-1:0]             mag_c;
    logic                         last_row_c;
    logic                         masked_c;
    logic                         take_c;

    for (genvar i = 0; i < VEC_LEN; i++) begin : g_unpack
        assign res_elem[i] = res_vec[DATA_WIDTH*i +: DATA_WIDTH];
    end

    assign elem_c     = res_elem[mac_row];
    assign rom_s      = $signed(rom_data);
    assign prod_c     = PROD_W'(elem_c) * PROD_W'(rom_s);
    assign prod_ext_c = ACC_WIDTH'(prod_c);
    assign final_c    = acc + prod_ext_c;
    assign ext_c      = MAG_W'(final_c);

    // One extra bit keeps |most-negative| representable
    always_comb begin
        mag_c = ext_c;
        if (ext_c[MAG_W-1]) begin
            mag_c = -ext_c;
        end
    end

`ifdef CORR_MASK_EN
    assign masked_c = col_mask[mac_col];
`else
    assign masked_c = 1'b0;
`endif

    logic [IDX_WIDTH-1:0]        run_best_idx;
    logic signed [ACC_WIDTH-1:0] run_best_corr;
    logic [MAG_W-1:0]            run_best_mag;
    logic                        have_best;

    assign last_row_c = mac_vld && (mac_row == ROW_LAST);
    // Strictly greater only, so ties keep the lowest index
    assign take_c = last_row_c && !masked_c && (!have_best || (mag_c > run_best_mag));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_vld       <= 1'b0;
            mac_row       <= '0;
            mac_col       <= '0;
            acc           <= '0;
            run_best_idx  <= '0;
            run_best_corr <= '0;
            run_best_mag  <= '0;
            have_best     <= 1'b0;
            best_idx      <= '0;
            best_corr     <= '0;
        end else begin
            mac_vld <= rom_rd_en;
            mac_row <= row;
            mac_col <= col;
            if (state == LOAD) begin
                acc           <= '0;
                run_best_idx  <= '0;
                run_best_corr <= '0;
                run_best_mag  <= '0;
                have_best     <= 1'b0;
            end else begin
                if (mac_vld) begin
                    acc <= last_row_c ? '0 : final_c;
                end
                if (take_c) begin
                    run_best_idx  <= mac_col;
                    run_best_corr <= final_c;
                    run_best_mag  <= mag_c;
                    have_best     <= 1'b1;
                end
            end
            // The last column finalises in DRAIN, so publish with it folded in
            if (state == DRAIN) begin
                best_idx  <= take_c ? mac_col : run_best_idx;
                best_corr <= take_c ? final_c : run_best_corr;
            end
        end
    end

endmodule

// File: tb/tb_corr_argmax.sv
// Directed bench for corr_argmax with a 4x4 dictionary; ROM and residual file are modelled here.
module tb_corr_argmax;

    localparam int DW   = 16;
    localparam int VL   = 4;
    localparam int NC   = 4;
    localparam int AW   = 4;
    localparam int IW   = 2;
    localparam int ACCW = 34;

    logic              clk;
    logic              rst;
    logic              start;
    logic              res_rd_en;
    logic [DW*VL-1:0]  res_vec;
    logic [DW*VL-1:0]  res_src;
    logic              rom_rd_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              busy;
    logic              done;
    logic [IW-1:0]     best_idx;
    logic [ACCW-1:0]   best_corr;
`ifdef CORR_MASK_EN
    logic [NC-1:0]     col_mask;
`endif

    logic [DW-1:0] rom [NC*VL];
    int checks;
    int errors;

    corr_argmax #(
        .DATA_WIDTH(DW), .VEC_LEN(VL), .NUM_COLS(NC),
        .ROM_ADDR_WIDTH(AW), .IDX_WIDTH(IW), .ACC_WIDTH(ACCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .res_rd_en(res_rd_en),
        .res_vec(res_vec),
        .rom_rd_en(rom_rd_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
`ifdef CORR_MASK_EN
        .col_mask(col_mask),
`endif
        .busy(busy),
        .done(done),
        .best_idx(best_idx),
        .best_corr(best_corr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM and residual register file
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= rom[rom_addr];
        if (res_rd_en) res_vec <= res_src;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_res(input int a, input int b, input int c, input int d);
        res_src = {DW'(d), DW'(c), DW'(b), DW'(a)};
    endtask

    task automatic set_identity();
        for (int i = 0; i < NC*VL; i++) rom[i] = '0;
        for (int j = 0; j < NC; j++) rom[j*VL + j] = DW'(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_rd_en"}, 64'(res_rd_en), 64'(0));
        check({tag, "_rom_rd_en"}, 64'(rom_rd_en), 64'(0));
        check({tag, "_rom_addr"},  64'(rom_addr),  64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
        check({tag, "_done"},      64'(done),      64'(0));
        check({tag, "_best_idx"},  64'(best_idx),  64'(0));
        check({tag, "_best_corr"}, 64'(best_corr), 64'(0));
    endtask

    // Cycle 1 is the cycle right after the edge that samples start; done is due in cycle 19
    task automatic run_search(input string tag, input int busy_cyc,
                              input logic [IW-1:0] exp_idx, input logic [ACCW-1:0] exp_corr);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            start = (cyc == busy_cyc);
            check($sformatf("%s_c%0d_res_rd_en", tag, cyc), 64'(res_rd_en), 64'(cyc == 1));
            check($sformatf("%s_c%0d_rom_rd_en", tag, cyc), 64'(rom_rd_en), 64'(cyc >= 2 && cyc <= 17));
            if (cyc >= 2 && cyc <= 17)
                check($sformatf("%s_c%0d_rom_addr", tag, cyc), 64'(rom_addr), 64'(cyc - 2));
            check($sformatf("%s_c%0d_busy", tag, cyc), 64'(busy), 64'(cyc <= 19));
            check($sformatf("%s_c%0d_done", tag, cyc), 64'(done), 64'(cyc == 19));
            if (cyc == 19 || cyc == 22) begin
                check($sformatf("%s_c%0d_best_idx", tag, cyc), 64'(best_idx), 64'(exp_idx));
                check($sformatf("%s_c%0d_best_corr", tag, cyc), 64'(best_corr), 64'(exp_corr));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        res_src = '0;
        set_identity();
`ifdef CORR_MASK_EN
        col_mask = '0;
`endif
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Identity columns pick out res elements: 5, -9, 3, 1
        set_res(5, -9, 3, 1);
        run_search("basic", 0, IW'(1), ACCW'(-9));

        // +7 in column 0 and -7 in column 2 tie on magnitude
        for (int i = 0; i < NC*VL; i++) rom[i] = '0;
        rom[0*VL + 3] = DW'(7);
        rom[1*VL + 2] = DW'(1);
        rom[2*VL + 3] = DW'(-7);
        rom[3*VL + 3] = DW'(1);
        run_search("tie", 0, IW'(0), ACCW'(7));

        // Four products of 2^30 per column must not wrap
        for (int i = 0; i < NC*VL; i++) rom[i] = 16'h8000;
        res_src = {4{16'h8000}};
        run_search("ovf", 0, IW'(0), ACCW'(64'd4294967296));

        // start pulsed during RUN is ignored
        set_identity();
        set_res(5, -9, 3, 1);
        run_search("busy_start", 8, IW'(1), ACCW'(-9));

        // Next start after returning to IDLE is accepted
        set_res(2, -1, -6, 4);
        run_search("after_busy", 0, IW'(2), ACCW'(-6));

        // Reset in cycle 10 aborts without done
        set_res(5, -9, 3, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_all_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            check($sformatf("post_rst_c%0d_done", cyc), 64'(done), 64'(0));
            check($sformatf("post_rst_c%0d_busy", cyc), 64'(busy), 64'(0));
        end
        run_search("post_rst", 0, IW'(1), ACCW'(-9));

`ifdef CORR_MASK_EN
        // Column 1 masked: column 0 (5) is next largest
        col_mask = 4'b0010;
        run_search("mask_one", 0, IW'(0), ACCW'(5));
        col_mask = 4'b1111;
        run_search("mask_all", 0, IW'(0), ACCW'(0));
        col_mask = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/corr_argmax.md
Name: corr_argmax

Overview:
- Atom-selection stage of the OMP datapath; sits directly downstream of the residual register file.
- On start, requests a parallel read of the residual vector, then streams every dictionary column from the dictionary ROM.
- Computes the inner product <r, a_j> for each column j with one MAC per cycle.
- Reports the column index with the largest |correlation| to the controller.

Parameters:
- DATA_WIDTH, 16: signed width of residual elements and ROM words (two's complement).
- VEC_LEN, 32: residual length and rows per column; equals the residual file size.
- NUM_COLS, 256: number of dictionary columns.
- ROM_ADDR_WIDTH, 13: ROM address width, at least clog2(NUM_COLS*VEC_LEN).
- IDX_WIDTH, 8: width of best_idx, at least clog2(NUM_COLS).
- ACC_WIDTH, 2*DATA_WIDTH+clog2(VEC_LEN): signed accumulator width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a search; sampled only in IDLE
- res_rd_en  out  1  read strobe to the residual file
- res_vec  in  DATA_WIDTH*VEC_LEN  flattened residual; element i at bits [DATA_WIDTH*(i+1)-1 -: DATA_WIDTH]
- rom_rd_en  out  1  dictionary ROM read enable
- rom_addr  out  ROM_ADDR_WIDTH  ROM address = col*VEC_LEN + row (column-major)
- rom_data  in  DATA_WIDTH  ROM word, valid 1 cycle after rom_rd_en
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; best_* valid in that cycle and held afterwards
- best_idx  out  IDX_WIDTH  winning column index
- best_corr  out  ACC_WIDTH  signed inner product of the winning column

Behaviour:
- Reset: state IDLE; res_rd_en=0, rom_rd_en=0, rom_addr=0, busy=0, done=0, best_idx=0, best_corr=0; accumulator and counters cleared. Reset mid-search aborts immediately; no done is issued.
- FSM:
  - IDLE: on start=1, go to LOAD.
  - LOAD: one cycle, res_rd_en=1; residual file updates its output at the following edge; go to RUN.
  - RUN: N=NUM_COLS*VEC_LEN cycles; rom_rd_en=1; rom_addr increments 0..N-1, one per cycle; go to DRAIN after address N-1.
  - DRAIN: one cycle; consumes the last ROM word; go to DONE.
  - DONE: one cycle, done=1; go to IDLE.
- Latency: done is high in cycle N+3, counting the cycle in which start is sampled as cycle 1.
- busy=1 in LOAD, RUN, DRAIN and DONE.
- start is ignored while not in IDLE.
- MAC stage runs one cycle behind address issue and uses a delayed row/col tag.
  - Product = signed rom_data * signed res_vec element[row], full 2*DATA_WIDTH bits, sign-extended into the accumulator; no rounding or saturation.
  - At row==VEC_LEN-1: final = acc + product; acc resets to 0 for the next column with no bubble.
- Compare:
  - Magnitude = |final|, computed with one extra bit so that the most-negative value does not overflow.
  - Column 0 is always taken as the initial best.
  - Column j replaces the best only if its magnitude is strictly greater, so ties keep the lowest index.
  - best_corr stores the signed final value, not the magnitude.
- best_idx and best_corr update only at the end of a search. They are updated in the DRAIN→DONE edge from the internal running best, and hold until the next done or reset.
- res_vec must stay stable from the cycle after LOAD through DRAIN; the controller must not write the residual file in that window.

Optional Feature:
- Macro CORR_MASK_EN.
- Defined:
  - Adds input col_mask [NUM_COLS-1:0]; a 1 marks a column already in the support.
  - Masked columns are still streamed, so timing is unchanged, but they are excluded from the compare.
  - The first unmasked column is the initial best.
  - If all columns are masked, done still pulses with best_idx=0 and best_corr=0.
  - col_mask must be stable while busy.
- Undefined: the port is absent and all columns compete.

Test Plan:
- All tests use VEC_LEN=4, NUM_COLS=4, DATA_WIDTH=16.
- Basic timing: ROM = identity-like columns, res_vec=[5,-9,3,1], start pulse → res_rd_en high for exactly 1 cycle; rom_addr 0..15 on consecutive cycles; done pulse in cycle 19; best_idx=1, best_corr=-9.
- Tie: columns 0 and 2 both give |corr|=7 (+7 and -7) → best_idx=0, best_corr=7.
- Overflow extremes: every element and ROM word = -32768 → per-column final = 4*2^30 with no wrap; best_idx=0, best_corr=+4294967296 in ACC_WIDTH bits.
- Start while busy: pulse start at cycle 8 of a search → ignored; exactly one done; next start accepted after returning to IDLE.
- Reset mid-RUN: assert rst at cycle 10 → all outputs 0 immediately; no done; a new search then completes correctly.
- With CORR_MASK_EN: col_mask=4'b0010 in the basic test → best_idx is the next-largest column (not 1). col_mask=4'b1111 → done in cycle 19 with best_idx=0, best_corr=0.
